// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: instruction-field transfer bus with valid/ready handshake
interface instr_encoder_loader_if;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  class_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        last_i;
  modport master(output valid_i, class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, last_i, input ready_o);
  modport slave(input valid_i, class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, last_i, output ready_o);
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32I fields and writes them sequentially into instruction memory
module instr_encoder_loader #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  localparam int         CW        = $clog2(MEM_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  instr_encoder_loader_if.slave  bus,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_data_o,
  output logic [CW-1:0]          count_o,
  output logic                   full_o,
  output logic                   error_o,
  output logic                   done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [31:0] enc;
  logic [31:0] imm;
  logic bad, sx11, sx12, fire, wr;
  assign full_o      = count_o == CW'(MEM_DEPTH);
  assign done_o      = state == DONE;
  assign error_o     = state == ERR;
  assign bus.ready_o = state == LOAD && !full_o;
  assign fire        = bus.valid_i && bus.ready_o && !start_i;
  assign wr          = fire && !bad;
  // assemble the instruction word and flag illegal classes or out-of-range immediates
  always_comb begin
    imm  = bus.imm_i;
    sx11 = &imm[31:11] | ~|imm[31:11];
    sx12 = &imm[31:12] | ~|imm[31:12];
    enc  = '0;
    bad  = 1'b0;
    case (bus.class_i)
      3'd0: enc = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0110011};
      3'd1: begin enc = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0010011}; bad = !sx11; end
      3'd2: begin enc = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, 7'b0000011}; bad = !sx11; end
      3'd3: begin enc = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], 7'b0100011}; bad = !sx11; end
      3'd4: begin enc = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:1], imm[11], 7'b1100011}; bad = !sx12 || imm[0]; end
      3'd5: begin enc = {imm[31:12], bus.rd_i, 7'b0110111}; bad = |imm[11:0]; end
      default: bad = 1'b1;
    endcase
  end
  // next state: restart dominates, then the outcome of an accepted transfer
  always_comb begin
    state_nx = state;
    if (start_i) state_nx = LOAD;
    else if (fire) state_nx = bad ? ERR : bus.last_i ? DONE : LOAD;
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // write port and word counter; address/data hold between writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      count_o    <= '0;
    end else begin
      mem_we_o <= wr;
      if (start_i) count_o <= '0;
      else if (wr) begin
        mem_addr_o <= BASE_ADDR + (32'(count_o) << 2);
        mem_data_o <= enc;
        count_o    <= count_o + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, handshake, errors, saturation and reset
module tb_instr_encoder_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic we, we_s, full, full_s, err, err_s, done, done_s;
  logic [31:0] addr, data, addr_s, data_s;
  logic [6:0] cnt;
  logic [2:0] cnt_s;
  int n_chk = 0;
  int n_fail = 0;
  int writes;
  instr_encoder_loader_if bi();
  instr_encoder_loader_if si();
  instr_encoder_loader dut (
    .clk(clk), .reset(reset), .start_i(start), .bus(bi),
    .mem_we_o(we), .mem_addr_o(addr), .mem_data_o(data), .count_o(cnt),
    .full_o(full), .error_o(err), .done_o(done)
  );
  instr_encoder_loader #(.MEM_DEPTH(4)) dut_s (
    .clk(clk), .reset(reset), .start_i(start_s), .bus(si),
    .mem_we_o(we_s), .mem_addr_o(addr_s), .mem_data_o(data_s), .count_o(cnt_s),
    .full_o(full_s), .error_o(err_s), .done_o(done_s)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, input logic last);
    bi.class_i = c; bi.rd_i = rd; bi.rs1_i = rs1; bi.rs2_i = rs2;
    bi.funct3_i = f3; bi.funct7_i = f7; bi.imm_i = imm; bi.last_i = last; bi.valid_i = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic idle();
    bi.valid_i = 1'b0; bi.last_i = 1'b0;
  endtask
  task automatic restart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d, input int c);
    check({tag, "_we"}, 32'(we), 32'd1);
    check({tag, "_addr"}, addr, a);
    check({tag, "_data"}, data, d);
    check({tag, "_cnt"}, 32'(cnt), 32'(c));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bi.valid_i = 0; bi.class_i = 0; bi.rd_i = 0; bi.rs1_i = 0; bi.rs2_i = 0;
    bi.funct3_i = 0; bi.funct7_i = 0; bi.imm_i = 0; bi.last_i = 0;
    si.valid_i = 0; si.class_i = 0; si.rd_i = 3; si.rs1_i = 1; si.rs2_i = 2;
    si.funct3_i = 0; si.funct7_i = 0; si.imm_i = 0; si.last_i = 0;
    #3;
    check("rst_we", 32'(we), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_flags", {28'd0, bi.ready_o, full, err, done}, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(bi.ready_o), 0);
    restart();
    check("load_ready", 32'(bi.ready_o), 1);
    xfer(0, 3, 1, 2, 0, 0, 0, 0);
    wr_chk("add", 32'h0040_0000, 32'h0020_81B3, 1);
    xfer(1, 5, 0, 0, 0, 0, 32'd10, 0);
    wr_chk("addi", 32'h0040_0004, 32'h00A0_0293, 2);
    xfer(2, 6, 5, 0, 2, 0, 32'd8, 0);
    wr_chk("lw", 32'h0040_0008, 32'h0082_A303, 3);
    xfer(3, 0, 5, 6, 2, 0, 32'd12, 0);
    wr_chk("sw", 32'h0040_000C, 32'h0062_A623, 4);
    xfer(5, 7, 0, 0, 0, 0, 32'h1234_5000, 0);
    wr_chk("lui", 32'h0040_0010, 32'h1234_53B7, 5);
    xfer(4, 0, 1, 2, 0, 0, 32'hFFFF_FFF8, 1);
    wr_chk("beq", 32'h0040_0014, 32'hFE20_8CE3, 6);
    check("beq_done", 32'(done), 1);
    check("beq_ready", 32'(bi.ready_o), 0);
    idle();
    @(posedge clk); #1;
    check("hold_we", 32'(we), 0);
    check("hold_data", data, 32'hFE20_8CE3);
    check("hold_done", 32'(done), 1);
    restart();
    check("rs_flags", {29'd0, full, err, done}, 0);
    check("rs_cnt", 32'(cnt), 0);
    xfer(6, 1, 1, 1, 0, 0, 0, 0);
    check("cls6_we", 32'(we), 0);
    check("cls6_err", 32'(err), 1);
    check("cls6_ready", 32'(bi.ready_o), 0);
    idle();
    restart();
    check("clr_err", 32'(err), 0);
    xfer(4, 0, 1, 2, 0, 0, 32'h0000_0003, 0);
    check("bimm_we", 32'(we), 0);
    check("bimm_err", 32'(err), 1);
    check("bimm_cnt", 32'(cnt), 0);
    idle();
    restart();
    xfer(1, 5, 0, 0, 0, 0, 32'd10, 0);
    check("pre_cnt", 32'(cnt), 1);
    xfer(1, 5, 0, 0, 0, 0, 32'h0000_0800, 0);
    check("iimm_we", 32'(we), 0);
    check("iimm_err", 32'(err), 1);
    check("iimm_cnt", 32'(cnt), 1);
    idle();
    restart();
    xfer(0, 3, 1, 2, 0, 0, 0, 0);
    check("mid_we", 32'(we), 1);
    idle();
    reset = 1'b0;
    #1;
    check("arst_we", 32'(we), 0);
    check("arst_cnt", 32'(cnt), 0);
    check("arst_ready", 32'(bi.ready_o), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bi.ready_o), 0);
    restart();
    xfer(0, 3, 1, 2, 0, 0, 0, 0);
    check("sv_cnt1", 32'(cnt), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle();
    check("sv_we", 32'(we), 0);
    check("sv_cnt0", 32'(cnt), 0);
    check("sv_ready", 32'(bi.ready_o), 1);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    si.valid_i = 1'b1;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (we_s) writes++;
    end
    si.valid_i = 1'b0;
    check("sat_writes", 32'(writes), 4);
    check("sat_cnt", 32'(cnt_s), 4);
    check("sat_full", 32'(full_s), 1);
    check("sat_ready", 32'(si.ready_o), 0);
    check("sat_addr", addr_s, 32'h0040_000C);
    check("sat_done", 32'(done_s), 0);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    check("sat_rs_cnt", 32'(cnt_s), 0);
    check("sat_rs_full", 32'(full_s), 0);
    si.valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      si.last_i = (i == 3);
      @(posedge clk); #1;
    end
    si.valid_i = 1'b0;
    si.last_i = 1'b0;
    check("last_full", 32'(full_s), 1);
    check("last_done", 32'(done_s), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
